// File: rtl/dcache_sram_arbiter.sv
// Arbitrates one D-cache bank SRAM port between the snoop controller (port 0) and the core-side
// controllers: snoop priority, round-robin among cores, starvation bound, and a lock for RMW sequences.
module dcache_sram_arbiter #(
    parameter int NR_PORTS = 3,
    parameter int WAYS     = 8,
    parameter int ADDR_W   = 12,
    parameter int TAG_W    = 44,
    parameter int DATA_W   = 128,
    parameter int MAX_WAIT = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NR_PORTS*WAYS-1:0]     req_i,
    input  logic [NR_PORTS-1:0]          lock_i,
    input  logic [NR_PORTS*ADDR_W-1:0]   addr_i,
    input  logic [NR_PORTS*TAG_W-1:0]    tag_i,
    input  logic [NR_PORTS-1:0]          we_i,
    input  logic [NR_PORTS*DATA_W-1:0]   wdata_i,
    input  logic [NR_PORTS*DATA_W/8-1:0] be_i,
    output logic [NR_PORTS-1:0]          gnt_o,
    output logic [NR_PORTS-1:0]          rvalid_o,
    output logic [WAYS-1:0]              sram_req_o,
    output logic [ADDR_W-1:0]            sram_addr_o,
    output logic [TAG_W-1:0]             sram_tag_o,
    output logic                         sram_we_o,
    output logic [DATA_W-1:0]            sram_wdata_o,
    output logic [DATA_W/8-1:0]          sram_be_o,
    input  logic                         sram_gnt_i,
    output logic                         busy_o
);
    localparam int BE_W  = DATA_W / 8;
    localparam int IDX_W = $clog2(NR_PORTS);
    localparam int ST_W  = $clog2(MAX_WAIT + 1);
    localparam logic [ST_W-1:0]  MAX_WAIT_C = ST_W'(MAX_WAIT);
    localparam logic [IDX_W-1:0] LAST_CORE  = IDX_W'(NR_PORTS - 1);

    typedef enum logic {IDLE, LOCKED} state_e;

    state_e             r_state;
    logic [IDX_W-1:0]   r_owner;
    logic [IDX_W-1:0]   r_rr;
    logic [ST_W-1:0]    r_starve;
    logic [NR_PORTS-1:0] r_rvalid;

    logic [NR_PORTS-1:0] w_port_req;
    logic                w_core_req;
    logic                w_rr_hit;
    logic [IDX_W-1:0]    w_rr_idx;
    logic                w_sel_valid;
    logic [IDX_W-1:0]    w_sel_idx;
    logic                w_grant;
    logic                w_core_gnt;

    always_comb begin
        for (int p = 0; p < NR_PORTS; p++) begin
            w_port_req[p] = |req_i[p*WAYS +: WAYS];
        end
    end

    assign w_core_req = |w_port_req[NR_PORTS-1:1];

    // First requesting core port at or after r_rr, wrapping past the last port back to port 1.
    always_comb begin
        int cand;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_rr_hit = 1'b0;
        w_rr_idx = '0;
        cand     = 0;
        for (int k = 0; k < NR_PORTS - 1; k++) begin
            cand = int'(r_rr) + k;
            if (cand > NR_PORTS - 1) begin
                cand = cand - (NR_PORTS - 1);
            end
            if (!w_rr_hit && w_port_req[IDX_W'(cand)]) begin
                w_rr_hit = 1'b1;
                w_rr_idx = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        if (!rst_i) begin
            if (r_state == LOCKED) begin
                if (w_port_req[r_owner]) begin
                    w_sel_valid = 1'b1;
                    w_sel_idx   = r_owner;
                end
            end else if (r_starve == MAX_WAIT_C && w_rr_hit) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = w_rr_idx;
            end else if (w_port_req[0]) begin
                w_sel_valid = 1'b1;
            end else if (w_rr_hit) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = w_rr_idx;
            end
        end
    end

    always_comb begin
        sram_req_o   = '0;
        sram_addr_o  = '0;
        sram_tag_o   = '0;
        sram_we_o    = 1'b0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        gnt_o        = '0;
        for (int p = 0; p < NR_PORTS; p++) begin
            if (w_sel_valid && w_sel_idx == IDX_W'(p)) begin
                sram_req_o   = req_i[p*WAYS +: WAYS];
                sram_addr_o  = addr_i[p*ADDR_W +: ADDR_W];
                sram_tag_o   = tag_i[p*TAG_W +: TAG_W];
                sram_we_o    = we_i[p];
                sram_wdata_o = wdata_i[p*DATA_W +: DATA_W];
                sram_be_o    = be_i[p*BE_W +: BE_W];
                gnt_o[p]     = sram_gnt_i;
            end
        end
    end

    assign w_grant    = |gnt_o;
    assign w_core_gnt = w_grant && (w_sel_idx != '0);
    assign rvalid_o   = r_rvalid;
    assign busy_o     = (r_state == LOCKED);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_rr     <= IDX_W'(1);
            r_starve <= '0;
            r_rvalid <= '0;
        end else begin
            r_rvalid <= gnt_o & ~we_i;

            if (w_core_gnt) begin
                r_starve <= '0;
                r_rr     <= (w_sel_idx == LAST_CORE) ? IDX_W'(1) : w_sel_idx + 1'b1;
            end else if (w_core_req && r_starve != MAX_WAIT_C) begin
                r_starve <= r_starve + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_grant && lock_i[w_sel_idx]) begin
                        r_state <= LOCKED;
                        r_owner <= w_sel_idx;
                    end
                end
                LOCKED: begin
                    // An owner that drops both request and lock abandons its sequence.
                    if (w_grant) begin
                        if (!lock_i[r_owner]) r_state <= IDLE;
                    end else if (!w_port_req[r_owner] && !lock_i[r_owner]) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_sram_arbiter.sv
// Directed test-plan steps followed by randomized traffic, all checked against a transaction-level
// model of the arbitration rules kept in this bench.
module tb_dcache_sram_arbiter;
    localparam int N  = 3;
    localparam int W  = 8;
    localparam int AW = 12;
    localparam int TW = 44;
    localparam int DW = 128;
    localparam int BW = DW / 8;
    localparam int MW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sgnt = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0]  t_req  [N];
    logic [AW-1:0] t_addr [N];
    logic [TW-1:0] t_tag  [N];
    logic [DW-1:0] t_data [N];
    logic [BW-1:0] t_be   [N];
    bit            t_we   [N];
    bit            t_lock [N];

    logic [N*W-1:0]  req;
    logic [N-1:0]    lock, we;
    logic [N*AW-1:0] addr;
    logic [N*TW-1:0] tag;
    logic [N*DW-1:0] wdata;
    logic [N*BW-1:0] be;

    for (genvar p = 0; p < N; p++) begin : g_pack
        assign req[p*W +: W]     = t_req[p];
        assign addr[p*AW +: AW]  = t_addr[p];
        assign tag[p*TW +: TW]   = t_tag[p];
        assign wdata[p*DW +: DW] = t_data[p];
        assign be[p*BW +: BW]    = t_be[p];
        assign we[p]             = t_we[p];
        assign lock[p]           = t_lock[p];
    end

    logic [N-1:0]  gnt_o, rvalid_o;
    logic [W-1:0]  sram_req_o;
    logic [AW-1:0] sram_addr_o;
    logic [TW-1:0] sram_tag_o;
    logic          sram_we_o;
    logic [DW-1:0] sram_wdata_o;
    logic [BW-1:0] sram_be_o;
    logic          busy_o;

    dcache_sram_arbiter #(
        .NR_PORTS(N), .WAYS(W), .ADDR_W(AW), .TAG_W(TW), .DATA_W(DW), .MAX_WAIT(MW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .lock_i(lock), .addr_i(addr), .tag_i(tag),
        .we_i(we), .wdata_i(wdata), .be_i(be), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
        .sram_req_o(sram_req_o), .sram_addr_o(sram_addr_o), .sram_tag_o(sram_tag_o),
        .sram_we_o(sram_we_o), .sram_wdata_o(sram_wdata_o), .sram_be_o(sram_be_o),
        .sram_gnt_i(sgnt), .busy_o(busy_o)
    );

    // Reference model state
    int           m_rr, m_starve, m_owner;
    bit           m_locked;
    logic [N-1:0] m_rvalid, m_last;

    int n_chk = 0;
    int n_err = 0;

    logic [N-1:0]  g_gnt, g_rvalid;
    logic          g_busy, g_we;
    logic [DW-1:0] g_wdata;

    task automatic chk(input string tg, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tg, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_rr = 1; m_starve = 0; m_owner = 0; m_locked = 0; m_rvalid = '0; m_last = '0;
    endfunction

    function automatic bit core_requesting();
        for (int p = 1; p < N; p++) if (t_req[p] != '0) return 1'b1;
        return 1'b0;
    endfunction

    // Returns the port the rules select this cycle, or -1 for none.
    function automatic int model_sel();
        int core = -1;
        if (rst) return -1;
        if (m_locked) return (t_req[m_owner] != '0) ? m_owner : -1;
        for (int i = 0; i < N - 1; i++) begin
            int p = 1 + (m_rr - 1 + i) % (N - 1);
            if (core < 0 && t_req[p] != '0) core = p;
        end
        if (m_starve == MW && core >= 0) return core;
        if (t_req[0] != '0) return 0;
        return core;
    endfunction

    task automatic cycle();
        int s;
        bit grant;
        logic [N-1:0]  e_gnt = '0;
        logic [W-1:0]  e_req = '0;
        logic [AW-1:0] e_addr = '0;
        logic [TW-1:0] e_tag = '0;
        logic          e_we = 1'b0;
        logic [DW-1:0] e_data = '0;
        logic [BW-1:0] e_be = '0;
        if (rst) model_reset();
        s = model_sel();
        grant = (s >= 0) && sgnt;
        if (s >= 0) begin
            e_req = t_req[s]; e_addr = t_addr[s]; e_tag = t_tag[s];
            e_we = t_we[s]; e_data = t_data[s]; e_be = t_be[s];
            if (sgnt) e_gnt[s] = 1'b1;
        end
        @(negedge clk);
        g_gnt = gnt_o; g_rvalid = rvalid_o; g_busy = busy_o; g_we = sram_we_o; g_wdata = sram_wdata_o;
        chk("gnt", gnt_o, e_gnt);
        chk("rvalid", rvalid_o, m_rvalid);
        chk("busy", busy_o, m_locked);
        chk("sram_req", sram_req_o, e_req);
        chk("sram_addr", sram_addr_o, e_addr);
        chk("sram_tag", sram_tag_o, e_tag);
        chk("sram_we", sram_we_o, e_we);
        chk("sram_wdata", sram_wdata_o, e_data);
        chk("sram_be", sram_be_o, e_be);
        if (!rst) begin
            m_rvalid = (grant && !t_we[s]) ? e_gnt : '0;
            if (grant && s != 0) begin
                m_starve = 0;
                m_rr = (s == N - 1) ? 1 : s + 1;
            end else if (core_requesting() && m_starve < MW) begin
                m_starve++;
            end
            if (!m_locked) begin
                if (grant && t_lock[s]) begin m_locked = 1; m_owner = s; end
            end else if (grant) begin
                m_locked = t_lock[s];
            end else if (t_req[m_owner] == '0 && !t_lock[m_owner]) begin
                m_locked = 0;
            end
            m_last = e_gnt;
        end else begin
            m_last = '0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p);
        t_req[p]  = W'($urandom_range(1, (1 << W) - 1));
        t_addr[p] = AW'($urandom());
        t_tag[p]  = TW'({$urandom(), $urandom()});
        t_data[p] = {$urandom(), $urandom(), $urandom(), $urandom()};
        t_be[p]   = BW'($urandom());
        t_we[p]   = 1'b0;
        t_lock[p] = 1'b0;
    endtask

    task automatic clr(input int p);
        t_req[p] = '0; t_addr[p] = '0; t_tag[p] = '0; t_data[p] = '0;
        t_be[p] = '0; t_we[p] = 1'b0; t_lock[p] = 1'b0;
    endtask

    task automatic do_reset();
        for (int p = 0; p < N; p++) clr(p);
        sgnt = 1'b1;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        for (int p = 0; p < N; p++) clr(p);
        model_reset();

        // Reset state and snoop-over-core ordering with read returns
        do_reset();
        chk("rst_busy", g_busy, 1'b0);
        chk("rst_gnt", g_gnt, 3'b000);
        set_rd(0); set_rd(1);
        cycle(); chk("tp1_gnt_a", g_gnt, 3'b001);
        clr(0);
        cycle(); chk("tp1_gnt_b", g_gnt, 3'b010); chk("tp1_rv_a", g_rvalid, 3'b001);
        clr(1);
        cycle(); chk("tp1_rv_b", g_rvalid, 3'b010);

        // Round-robin alternation between cores
        do_reset();
        set_rd(1); set_rd(2);
        for (int i = 0; i < 4; i++) begin
            cycle(); chk("tp2_rr", g_gnt, (i % 2 == 0) ? 3'b010 : 3'b100);
        end

        // Starvation preemption after MAX_WAIT snoop grants
        do_reset();
        set_rd(0); set_rd(1);
        for (int i = 0; i < MW + 2; i++) begin
            cycle(); chk("tp3_starve", g_gnt, (i == MW) ? 3'b010 : 3'b001);
        end

        // Lock holds off the snoop until released
        do_reset();
        set_rd(1); t_lock[1] = 1'b1;
        cycle(); chk("tp4_gnt_lock", g_gnt, 3'b010);
        t_req[1] = '0;
        set_rd(0);
        cycle(); chk("tp4_busy", g_busy, 1'b1); chk("tp4_wait", g_gnt, 3'b000);
        set_rd(1);
        cycle(); chk("tp4_owner", g_gnt, 3'b010); chk("tp4_busy2", g_busy, 1'b1);
        clr(1);
        cycle(); chk("tp4_free", g_busy, 1'b0); chk("tp4_snoop", g_gnt, 3'b001);
        clr(0);

        // Write from port 2
        do_reset();
        set_rd(2); t_we[2] = 1'b1; t_be[2] = '1;
        cycle(); chk("tp5_gnt", g_gnt, 3'b100); chk("tp5_we", g_we, 1'b1);
        chk("tp5_wdata", g_wdata, t_data[2]);
        clr(2);
        cycle(); chk("tp5_norv", g_rvalid, 3'b000);

        // SRAM refusals count towards starvation
        do_reset();
        set_rd(1); sgnt = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle(); chk("tp6_refused", g_gnt, 3'b000);
        end
        sgnt = 1'b1;
        set_rd(0);
        for (int i = 0; i < 6; i++) begin
            cycle(); chk("tp6_starve3", g_gnt, (i == 5) ? 3'b010 : 3'b001);
        end
        clr(0); clr(1);

        // Reset while locked with a read in flight
        set_rd(1); t_lock[1] = 1'b1;
        cycle(); chk("tp6_lock", g_gnt, 3'b010);
        t_req[1] = '0;
        rst = 1'b1;
        cycle(); chk("tp6_rst_busy", g_busy, 1'b0); chk("tp6_rst_rv", g_rvalid, 3'b000);
        cycle();
        rst = 1'b0;
        clr(1);
        set_rd(1); set_rd(2);
        cycle(); chk("tp6_rr1", g_gnt, 3'b010);
        for (int p = 0; p < N; p++) clr(p);
        cycle();

        // Randomized traffic honouring the hold-until-granted protocol
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < N; p++) begin
                if (m_last[p]) begin
                    if ($urandom_range(0, 1) == 0) clr(p);
                    else begin
                        set_rd(p);
                        t_we[p] = 1'($urandom_range(0, 1));
                        t_lock[p] = ($urandom_range(0, 5) == 0);
                    end
                end else if (t_req[p] == '0 && $urandom_range(0, 9) < 4) begin
                    set_rd(p);
                    t_we[p] = 1'($urandom_range(0, 1));
                    t_lock[p] = ($urandom_range(0, 5) == 0);
                end
            end
            sgnt = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/dcache_sram_arbiter.md
Name: dcache_sram_arbiter

Overview:
- Shares the single data/tag SRAM port of one D-cache bank between the snoop cache controller (port 0) and NR_PORTS-1 core-side cache controllers (ports 1..NR_PORTS-1).
- Snoop traffic has fixed priority. Core ports are served round-robin.
- A starvation counter bounds how long core ports can wait behind snoops.
- A lock mechanism gives one requester exclusive back-to-back access for read-modify-write sequences.

Parameters:
NR_PORTS, 3, number of requesters; port 0 is the snoop controller; must be >= 2
WAYS, 8, set associativity (width of per-way request vector)
ADDR_W, 12, SRAM index width
TAG_W, 44, tag width
DATA_W, 128, cache line data width
MAX_WAIT, 8, cycles a core request may be refused before it preempts the snoop port; must be >= 1

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
req_i  in  NR_PORTS*WAYS  per-port per-way request
lock_i  in  NR_PORTS  keep ownership after this grant
addr_i  in  NR_PORTS*ADDR_W  per-port index
tag_i  in  NR_PORTS*TAG_W  per-port tag
we_i  in  NR_PORTS  per-port write enable
wdata_i  in  NR_PORTS*DATA_W  per-port write data
be_i  in  NR_PORTS*(DATA_W/8)  per-port byte enables
gnt_o  out  NR_PORTS  request accepted this cycle
rvalid_o  out  NR_PORTS  read data on SRAM return bus belongs to this port
sram_req_o  out  WAYS  muxed request to SRAM
sram_addr_o  out  ADDR_W  muxed index
sram_tag_o  out  TAG_W  muxed tag
sram_we_o  out  1  muxed write enable
sram_wdata_o  out  DATA_W  muxed write data
sram_be_o  out  DATA_W/8  muxed byte enables
sram_gnt_i  in  1  SRAM accepted sram_req_o this cycle
busy_o  out  1  arbiter is in LOCKED state

Behaviour:
- Port p is requesting when |req_i[p] is high.
- Selection is combinational, in this priority order:
  1. LOCKED: only the owner may be selected.
  2. Starvation: if starve_q == MAX_WAIT and any core port requests, pick the first requesting core port at or after rr_q, wrapping from NR_PORTS-1 back to 1.
  3. Snoop: if port 0 requests, pick port 0.
  4. Otherwise pick a core port round-robin from rr_q, with the same wrap as rule 2.
- The sram_* outputs carry the selected port's signals. When nothing is selected, all sram_* outputs are 0.
- gnt_o[p] = selected[p] & sram_gnt_i. The grant is combinational in the same cycle as the request.
- Requesters hold req/addr/tag/we/data/be stable until granted. The arbiter may change its selection between cycles while no grant has occurred.
- Round-robin pointer: on a grant to core port p, rr_q <= p+1, wrapping NR_PORTS-1 -> 1. A grant to port 0 leaves rr_q unchanged.
- starve_q:
  - Reset to 0 in any cycle a core port is granted.
  - Otherwise incremented when any core port requests and none is granted.
  - Saturates at MAX_WAIT.
  - Held when no core port requests.
- Read return: the SRAM delivers data one cycle after its grant.
  - On gnt_o[p] with we_i[p]=0, rvalid_o[p] is 1 in the following cycle and 0 otherwise.
  - Writes never raise rvalid_o.
  - Read data and hit information go directly from the SRAM to all requesters; they are not routed through this block.
- FSM states:
  - IDLE -> LOCKED when gnt_o[p] and lock_i[p]; owner_q <= p.
  - LOCKED -> IDLE when owner is granted with lock_i[owner]=0, or when owner has no request and lock_i[owner]=0 (abort).
  - LOCKED -> LOCKED on a grant to owner with lock_i[owner]=1.
  - While LOCKED: starve_q still counts; a snoop request waits; no preemption.
- busy_o = (state_q == LOCKED).
- Reset values:
  - state_q=IDLE, owner_q=0, rr_q=1, starve_q=0.
  - rvalid_o=0, gnt_o=0, busy_o=0, all sram_* = 0 while reset is asserted.
- Reset asserted mid-lock or with a read in flight: state returns to IDLE immediately and the pending rvalid_o is dropped.
- Simultaneous events:
  - Snoop and core requests in the same cycle: the snoop wins unless starve_q == MAX_WAIT.
  - Grant and lock release in the same cycle: the release takes effect next cycle.
- sram_gnt_i=0: no gnt_o. Selection is re-evaluated next cycle. starve_q counts as refused.

Test Plan:
- NR_PORTS=3; ports 0 and 1 both request reads, sram_gnt_i=1 -> gnt_o=001; port 1 granted next cycle; rvalid_o=001 then 010 on the following cycles.
- Ports 1 and 2 request continuously, rr_q=1 -> grants alternate 010, 100, 010, ...; rr_q wraps 2 -> 1.
- Port 0 and port 1 request continuously, MAX_WAIT=8 -> port 0 granted 8 cycles; in cycle 9 gnt_o=010 and starve_q returns to 0.
- Port 1 granted a read with lock_i=1 -> busy_o=1. Port 0 request stays ungranted while port 1 is granted its next access with lock_i=0. busy_o=0 next cycle and port 0 is granted.
- Port 2 write (we=1, be=all ones) granted -> sram_we_o=1 with port 2 data; rvalid_o stays 000.
- sram_gnt_i=0 for 3 cycles with port 1 requesting -> gnt_o=000 and starve_q=3. Assert rst_i while LOCKED -> busy_o=0, rvalid_o=000, rr_q=1 after release.
